// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and fills
// the IF/ID register, honouring stall, redirects and the end-of-memory halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_addr_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        align_err_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  // 33 bits so the limit and pc+4 never overflow in the compare
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        aerr_q, aerr_d;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] tgt_al;
  logic        tgt_in;
  logic [32:0] seq_pc;
  logic        seq_end;

  assign redir   = branch_taken_i | jump_i;
  assign tgt     = branch_taken_i ? branch_target_i : jump_target_i;
  assign tgt_al  = tgt & ~32'h3;
  assign tgt_in  = {1'b0, tgt_al} < LIMIT;
  assign seq_pc  = {1'b0, pc_q} + 33'd4;
  assign seq_end = seq_pc >= LIMIT;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    aerr_d  = aerr_q;
    if (redir) begin
      pc_d   = tgt_al;
      ifid_d = '0;
      if (tgt[1:0] != 2'b00) aerr_d = 1'b1;
      state_d = tgt_in ? RUN : HALT;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d      = RUN;
          ifid_d.valid = 1'b0;
        end
        RUN: begin
          if (!stall_i) begin
            ifid_d.instr = instr_i;
            ifid_d.pc4   = seq_pc[31:0];
            ifid_d.valid = 1'b1;
            cnt_d        = cnt_q + 32'd1;
            // last in-range word is captured, PC parks on it
            if (seq_end) state_d = HALT;
            else         pc_d    = seq_pc[31:0];
          end
        end
        HALT: begin
          ifid_d.valid = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      cnt_q   <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
      aerr_q  <= aerr_d;
    end
  end

  assign pc_addr_o     = pc_q;
  assign if_id_instr_o = ifid_q.instr;
  assign if_id_pc4_o   = ifid_q.pc4;
  assign if_id_valid_o = ifid_q.valid;
  assign halted_o      = (state_q == HALT);
  assign align_err_o   = aerr_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory
// whose word content is 0xA000_0000 | byte address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_tgt = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        halted;
  logic        aerr;
  logic [31:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign instr = 32'hA000_0000 | pc;

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .stall_i(stall),
    .branch_taken_i(br),
    .branch_target_i(br_tgt),
    .jump_i(jmp),
    .jump_target_i(jmp_tgt),
    .instr_i(instr),
    .pc_addr_o(pc),
    .if_id_instr_o(id_instr),
    .if_id_pc4_o(id_pc4),
    .if_id_valid_o(id_valid),
    .halted_o(halted),
    .align_err_o(aerr),
    .fetch_count_o(cnt)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    step(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_aerr", 32'(aerr), 32'd0);

    // IDLE one cycle, then sequential fetch
    rst = 1'b1;
    step(1);
    chk("idle_pc", pc, 32'h0);
    chk("idle_valid", 32'(id_valid), 32'd0);
    step(1);
    chk("f0_pc", pc, 32'h4);
    chk("f0_instr", id_instr, 32'hA000_0000);
    chk("f0_pc4", id_pc4, 32'h4);
    chk("f0_valid", 32'(id_valid), 32'd1);
    chk("f0_cnt", cnt, 32'd1);
    step(3);
    chk("f3_pc", pc, 32'h10);
    chk("f3_instr", id_instr, 32'hA000_000C);
    chk("f3_cnt", cnt, 32'd4);

    // stall three cycles
    stall = 1'b1;
    step(3);
    chk("st_pc", pc, 32'h10);
    chk("st_pc4", id_pc4, 32'h10);
    chk("st_instr", id_instr, 32'hA000_000C);
    chk("st_cnt", cnt, 32'd4);
    stall = 1'b0;
    step(1);
    chk("res_pc", pc, 32'h14);
    chk("res_instr", id_instr, 32'hA000_0010);
    chk("res_cnt", cnt, 32'd5);

    // branch beats jump and stall
    br = 1'b1; br_tgt = 32'h40;
    jmp = 1'b1; jmp_tgt = 32'h08;
    stall = 1'b1;
    step(1);
    br = 1'b0; jmp = 1'b0; stall = 1'b0;
    chk("br_pc", pc, 32'h40);
    chk("br_valid", 32'(id_valid), 32'd0);
    chk("br_instr", id_instr, 32'h0);
    chk("br_cnt", cnt, 32'd5);
    step(1);
    chk("br_pc4", id_pc4, 32'h44);
    chk("br_cap", id_instr, 32'hA000_0040);
    chk("br_cnt2", cnt, 32'd6);

    // run to end of memory
    step(14);
    chk("end_pc", pc, 32'd124);
    chk("end_halt0", 32'(halted), 32'd0);
    step(1);
    chk("last_pc4", id_pc4, 32'd128);
    chk("last_valid", 32'(id_valid), 32'd1);
    chk("last_halt", 32'(halted), 32'd1);
    chk("last_pc", pc, 32'd124);
    chk("last_cnt", cnt, 32'd21);
    step(2);
    chk("hlt_valid", 32'(id_valid), 32'd0);
    chk("hlt_pc", pc, 32'd124);
    chk("hlt_cnt", cnt, 32'd21);

    // misaligned jump from HALT
    jmp = 1'b1; jmp_tgt = 32'h22;
    step(1);
    jmp = 1'b0;
    chk("mis_pc", pc, 32'h20);
    chk("mis_aerr", 32'(aerr), 32'd1);
    chk("mis_halt", 32'(halted), 32'd0);
    step(1);
    chk("mis_pc2", pc, 32'h24);
    chk("mis_pc4", id_pc4, 32'h24);
    chk("mis_sticky", 32'(aerr), 32'd1);

    // out-of-range jump halts, in-range jump resumes
    jmp = 1'b1; jmp_tgt = 32'h1000;
    step(1);
    chk("oor_halt", 32'(halted), 32'd1);
    chk("oor_pc", pc, 32'h1000);
    jmp_tgt = 32'h0;
    step(1);
    jmp = 1'b0;
    chk("rej_halt", 32'(halted), 32'd0);
    chk("rej_pc", pc, 32'h0);
    step(1);
    chk("rej_pc2", pc, 32'h4);
    chk("rej_cnt", cnt, 32'd23);
    step(11);
    chk("pre_rst_pc", pc, 32'h30);
    chk("pre_rst_cnt", cnt, 32'd34);

    // reset mid-run
    rst = 1'b0;
    step(1);
    chk("mr_pc", pc, 32'h0);
    chk("mr_valid", 32'(id_valid), 32'd0);
    chk("mr_pc4", id_pc4, 32'h0);
    chk("mr_cnt", cnt, 32'd0);
    chk("mr_aerr", 32'(aerr), 32'd0);
    chk("mr_halt", 32'(halted), 32'd0);
    rst = 1'b1;
    step(1);
    chk("mr_idle_pc", pc, 32'h0);
    chk("mr_idle_v", 32'(id_valid), 32'd0);
    step(1);
    chk("mr_run_pc", pc, 32'h4);
    chk("mr_run_cnt", cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
